// File: rtl/mem_ctrl_if.sv
// Request/response and byte-bus bundle for mem_ctrl: fetch port, load/store port,
// status flags and the 8-bit RAM/IO bus.
interface mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_done_o;
    logic [31:0]       if_inst_o;

    logic              ls_req_i;
    logic              ls_we_i;
    logic [1:0]        ls_size_i;
    logic              ls_sext_i;
    logic [ADDR_W-1:0] ls_addr_i;
    logic [31:0]       ls_wdata_i;
    logic              ls_done_o;
    logic [31:0]       ls_rdata_o;

    logic              busy_o;
    logic              err_o;

    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [31:0]       mem_a;
    logic              mem_wr;

    modport slave (
        input  if_req_i, if_addr_i,
        input  ls_req_i, ls_we_i, ls_size_i, ls_sext_i, ls_addr_i, ls_wdata_i,
        input  mem_din,
        output if_done_o, if_inst_o, ls_done_o, ls_rdata_o,
        output busy_o, err_o,
        output mem_dout, mem_a, mem_wr
    );

    modport master (
        output if_req_i, if_addr_i,
        output ls_req_i, ls_we_i, ls_size_i, ls_sext_i, ls_addr_i, ls_wdata_i,
        output mem_din,
        input  if_done_o, if_inst_o, ls_done_o, ls_rdata_o,
        input  busy_o, err_o,
        input  mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: splits fetch and load/store words into 8-bit bus cycles.
// Optional MEM_CTRL_ALIGN_CHK_EN rejects misaligned half/word accesses with err_o.
module mem_ctrl #(
    parameter int ADDR_W  = 32,
    parameter bit IF_PRIO = 1'b0
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rdy_in,
    mem_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;

    state_t            state_r, state_nx_s;
    logic [ADDR_W-1:0] base_r, base_nx_s;
    logic [2:0]        cnt_r, cnt_nx_s;
    logic [1:0]        size_r, size_nx_s;
    logic              sext_r, sext_nx_s;
    logic              we_r, we_nx_s;
    logic              who_if_r, who_if_nx_s;
    logic [31:0]       wdata_r, wdata_nx_s;
    logic [2:0]        iss_r, iss_nx_s;
    logic [2:0]        cap_r, cap_nx_s;
    logic              bus_v_r, bus_v_nx_s;
    logic              din_v_r, din_v_nx_s;
    logic [31:0]       buf_r, buf_nx_s;
    logic [31:0]       mem_a_r, mem_a_nx_s;
    logic [7:0]        mem_dout_r, mem_dout_nx_s;
    logic              mem_wr_r, mem_wr_nx_s;
    logic              if_done_r, if_done_nx_s;
    logic              ls_done_r, ls_done_nx_s;
    logic [31:0]       if_inst_r, if_inst_nx_s;
    logic [31:0]       ls_rdata_r, ls_rdata_nx_s;
    logic              busy_r, busy_nx_s;
    logic              err_r, err_nx_s;

    logic              grant_if_s, grant_ls_s;
    logic [ADDR_W-1:0] req_addr_s, issue_addr_s;
    logic [1:0]        req_size_s;
    logic [2:0]        req_cnt_s;
    logic              misalign_s;

    function automatic logic [31:0] extend_load(input logic [31:0] data,
                                                input logic [1:0]  size,
                                                input logic        sext);
        logic [31:0] res;
        case (size)
            2'd0:    res = {{24{sext & data[7]}}, data[7:0]};
            2'd1:    res = {{16{sext & data[15]}}, data[15:0]};
            default: res = data;
        endcase
        return res;
    endfunction

    assign grant_ls_s   = bus.ls_req_i & (~IF_PRIO | ~bus.if_req_i);
    assign grant_if_s   = bus.if_req_i & ~grant_ls_s;
    assign req_addr_s   = grant_if_s ? bus.if_addr_i : bus.ls_addr_i;
    assign req_size_s   = grant_if_s ? 2'd2 : bus.ls_size_i;
    assign req_cnt_s    = (req_size_s == 2'd0) ? 3'd1 : ((req_size_s == 2'd1) ? 3'd2 : 3'd4);
    assign issue_addr_s = base_r + ADDR_W'(iss_r);

`ifdef MEM_CTRL_ALIGN_CHK_EN
    assign misalign_s = ((req_size_s == 2'd1) && req_addr_s[0]) ||
                        (req_size_s[1] && (req_addr_s[1:0] != 2'b00));
`else
    assign misalign_s = 1'b0;
`endif

    // Next-state, datapath and output-register computation.
    always_comb begin
        state_nx_s    = state_r;
        base_nx_s     = base_r;
        cnt_nx_s      = cnt_r;
        size_nx_s     = size_r;
        sext_nx_s     = sext_r;
        we_nx_s       = we_r;
        who_if_nx_s   = who_if_r;
        wdata_nx_s    = wdata_r;
        iss_nx_s      = iss_r;
        cap_nx_s      = cap_r;
        bus_v_nx_s    = bus_v_r;
        din_v_nx_s    = din_v_r;
        buf_nx_s      = buf_r;
        mem_a_nx_s    = mem_a_r;
        mem_dout_nx_s = mem_dout_r;
        mem_wr_nx_s   = mem_wr_r;
        if_done_nx_s  = if_done_r;
        ls_done_nx_s  = ls_done_r;
        if_inst_nx_s  = if_inst_r;
        ls_rdata_nx_s = ls_rdata_r;
        err_nx_s      = err_r;

        if (rdy_in) begin
            case (state_r)
                IDLE: begin
                    if (grant_if_s || grant_ls_s) begin
                        base_nx_s   = req_addr_s;
                        cnt_nx_s    = req_cnt_s;
                        size_nx_s   = req_size_s;
                        sext_nx_s   = grant_ls_s & bus.ls_sext_i;
                        we_nx_s     = grant_ls_s & bus.ls_we_i;
                        who_if_nx_s = grant_if_s;
                        wdata_nx_s  = bus.ls_wdata_i;
                        buf_nx_s    = 32'h0000_0000;
                        cap_nx_s    = 3'd0;
                        din_v_nx_s  = 1'b0;
                        if (misalign_s) begin
                            // Rejected access: complete on the next cycle without touching the bus.
                            state_nx_s = DONE;
                            err_nx_s   = 1'b1;
                            iss_nx_s   = 3'd0;
                            bus_v_nx_s = 1'b0;
                            if (grant_if_s) begin
                                if_done_nx_s = 1'b1;
                                if_inst_nx_s = 32'h0000_0000;
                            end else begin
                                ls_done_nx_s  = 1'b1;
                                ls_rdata_nx_s = 32'h0000_0000;
                            end
                        end else begin
                            mem_a_nx_s = 32'(req_addr_s);
                            iss_nx_s   = 3'd1;
                            if (grant_ls_s && bus.ls_we_i) begin
                                state_nx_s    = WRITE;
                                mem_dout_nx_s = bus.ls_wdata_i[7:0];
                                mem_wr_nx_s   = 1'b1;
                                bus_v_nx_s    = 1'b0;
                            end else begin
                                state_nx_s = READ;
                                bus_v_nx_s = 1'b1;
                            end
                        end
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                READ: begin
                    din_v_nx_s = bus_v_r;
                    if (din_v_r) begin
                        buf_nx_s[{cap_r[1:0], 3'b000} +: 8] = bus.mem_din;
                        cap_nx_s = cap_r + 3'd1;
                    end else begin
                        cap_nx_s = cap_r;
                    end
                    if (iss_r < cnt_r) begin
                        mem_a_nx_s = 32'(issue_addr_s);
                        iss_nx_s   = iss_r + 3'd1;
                        bus_v_nx_s = 1'b1;
                    end else begin
                        mem_a_nx_s = 32'h0000_0000;
                        bus_v_nx_s = 1'b0;
                    end
                    if (din_v_r && ((cap_r + 3'd1) == cnt_r)) begin
                        state_nx_s = DONE;
                        mem_a_nx_s = 32'h0000_0000;
                        bus_v_nx_s = 1'b0;
                        din_v_nx_s = 1'b0;
                        if (who_if_r) begin
                            if_done_nx_s = 1'b1;
                            if_inst_nx_s = buf_nx_s;
                        end else begin
                            ls_done_nx_s  = 1'b1;
                            ls_rdata_nx_s = extend_load(buf_nx_s, size_r, sext_r);
                        end
                    end else begin
                        state_nx_s = READ;
                    end
                end
                WRITE: begin
                    if (iss_r < cnt_r) begin
                        mem_a_nx_s    = 32'(issue_addr_s);
                        mem_dout_nx_s = wdata_r[{iss_r[1:0], 3'b000} +: 8];
                        iss_nx_s      = iss_r + 3'd1;
                    end else begin
                        state_nx_s    = DONE;
                        mem_a_nx_s    = 32'h0000_0000;
                        mem_dout_nx_s = 8'h00;
                        mem_wr_nx_s   = 1'b0;
                        ls_done_nx_s  = 1'b1;
                    end
                end
                DONE: begin
                    state_nx_s   = IDLE;
                    if_done_nx_s = 1'b0;
                    ls_done_nx_s = 1'b0;
                    err_nx_s     = 1'b0;
                end
                default: begin
                    state_nx_s = IDLE;
                end
            endcase
        end else if (state_r == READ) begin
            // Reads in flight are lost while frozen; restart issue at the first uncaptured byte.
            iss_nx_s   = cap_r;
            bus_v_nx_s = 1'b0;
            din_v_nx_s = 1'b0;
        end else begin
            state_nx_s = state_r;
        end

        busy_nx_s = (state_nx_s != IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r    <= IDLE;
            base_r     <= '0;
            cnt_r      <= 3'd0;
            size_r     <= 2'd0;
            sext_r     <= 1'b0;
            we_r       <= 1'b0;
            who_if_r   <= 1'b0;
            wdata_r    <= 32'h0000_0000;
            iss_r      <= 3'd0;
            cap_r      <= 3'd0;
            bus_v_r    <= 1'b0;
            din_v_r    <= 1'b0;
            buf_r      <= 32'h0000_0000;
            mem_a_r    <= 32'h0000_0000;
            mem_dout_r <= 8'h00;
            mem_wr_r   <= 1'b0;
            if_done_r  <= 1'b0;
            ls_done_r  <= 1'b0;
            if_inst_r  <= 32'h0000_0000;
            ls_rdata_r <= 32'h0000_0000;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            base_r     <= base_nx_s;
            cnt_r      <= cnt_nx_s;
            size_r     <= size_nx_s;
            sext_r     <= sext_nx_s;
            we_r       <= we_nx_s;
            who_if_r   <= who_if_nx_s;
            wdata_r    <= wdata_nx_s;
            iss_r      <= iss_nx_s;
            cap_r      <= cap_nx_s;
            bus_v_r    <= bus_v_nx_s;
            din_v_r    <= din_v_nx_s;
            buf_r      <= buf_nx_s;
            mem_a_r    <= mem_a_nx_s;
            mem_dout_r <= mem_dout_nx_s;
            mem_wr_r   <= mem_wr_nx_s;
            if_done_r  <= if_done_nx_s;
            ls_done_r  <= ls_done_nx_s;
            if_inst_r  <= if_inst_nx_s;
            ls_rdata_r <= ls_rdata_nx_s;
            busy_r     <= busy_nx_s;
            err_r      <= err_nx_s;
        end
    end

    assign bus.if_done_o  = if_done_r;
    assign bus.if_inst_o  = if_inst_r;
    assign bus.ls_done_o  = ls_done_r;
    assign bus.ls_rdata_o = ls_rdata_r;
    assign bus.busy_o     = busy_r;
    assign bus.err_o      = err_r;
    assign bus.mem_a      = mem_a_r;
    assign bus.mem_dout   = mem_dout_r;
    // A frozen cycle must never commit a write; the same byte is driven again afterwards.
    assign bus.mem_wr     = mem_wr_r & rdy_in;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a one-cycle registered byte RAM on the bus.
module tb_mem_ctrl;
    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic rdy_in = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic       pre_we = 1'b0;
    logic [9:0] pre_a  = 10'd0;
    logic [7:0] pre_d  = 8'h00;
    logic [7:0] ram [0:1023];

    logic [31:0] log_a [48];
    logic [7:0]  log_d [48];
    logic        log_w [48];
    logic        log_busy [48];
    int          done_cyc;
    logic        got_err;
    logic        wr_any;

    mem_ctrl_if #(.ADDR_W(32)) bus ();

    mem_ctrl #(.ADDR_W(32), .IF_PRIO(1'b0)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        if (pre_we) ram[pre_a] <= pre_d;
        else if (bus.mem_wr) ram[bus.mem_a[9:0]] <= bus.mem_dout;
        bus.mem_din <= ram[bus.mem_a[9:0]];
    end

    task automatic preload(input logic [9:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_in); #1;
            pre_we = 1'b1;
            pre_a  = a + 10'(i);
            pre_d  = w[8*i +: 8];
        end
        @(posedge clk_in); #1;
        pre_we = 1'b0;
    endtask

    task automatic run_txn(input logic is_if, input logic we, input logic [1:0] size,
                           input logic sext, input logic [31:0] addr, input logic [31:0] wdata,
                           input int st_lo, input int st_hi);
        @(posedge clk_in); #1;
        if (is_if) begin
            bus.if_req_i  = 1'b1;
            bus.if_addr_i = addr;
        end else begin
            bus.ls_req_i   = 1'b1;
            bus.ls_we_i    = we;
            bus.ls_size_i  = size;
            bus.ls_sext_i  = sext;
            bus.ls_addr_i  = addr;
            bus.ls_wdata_i = wdata;
        end
        done_cyc = -1;
        got_err  = 1'b0;
        wr_any   = 1'b0;
        for (int c = 0; c < 40 && done_cyc < 0; c++) begin
            if (c > 0) begin
                @(posedge clk_in); #1;
            end
            rdy_in = !(c >= st_lo && c <= st_hi);
            @(negedge clk_in);
            log_a[c]    = bus.mem_a;
            log_d[c]    = bus.mem_dout;
            log_w[c]    = bus.mem_wr;
            log_busy[c] = bus.busy_o;
            wr_any      = wr_any | bus.mem_wr;
            if (bus.if_done_o || bus.ls_done_o) begin
                done_cyc      = c;
                got_err       = bus.err_o;
                bus.if_req_i  = 1'b0;
                bus.ls_req_i  = 1'b0;
            end
        end
        rdy_in = 1'b1;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        checks++; if (bus.if_done_o !== 1'b0) begin errors++; $display("FAIL reset_if_done got %b want 0", bus.if_done_o); end
        checks++; if (bus.ls_done_o !== 1'b0) begin errors++; $display("FAIL reset_ls_done got %b want 0", bus.ls_done_o); end
        checks++; if (bus.if_inst_o !== 32'h0) begin errors++; $display("FAIL reset_inst got %h want 0", bus.if_inst_o); end
        checks++; if (bus.ls_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", bus.ls_rdata_o); end
        checks++; if (bus.mem_a !== 32'h0) begin errors++; $display("FAIL reset_mem_a got %h want 0", bus.mem_a); end
        checks++; if (bus.mem_dout !== 8'h0) begin errors++; $display("FAIL reset_mem_dout got %h want 0", bus.mem_dout); end
        checks++; if (bus.mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr got %b want 0", bus.mem_wr); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy_o); end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.err_o); end
    endtask

    task automatic test_fetch;
        run_txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, -1, -1);
        checks++; if (done_cyc != 6) begin errors++; $display("FAIL fetch_done_cycle got %0d want 6", done_cyc); end
        checks++; if (bus.if_inst_o !== 32'h0010_0513) begin errors++; $display("FAIL fetch_inst got %h want 00100513", bus.if_inst_o); end
        checks++; if (log_busy[1] !== 1'b1) begin errors++; $display("FAIL fetch_busy got %b want 1", log_busy[1]); end
        checks++; if (wr_any !== 1'b0) begin errors++; $display("FAIL fetch_no_write got %b want 0", wr_any); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_a[i+1] !== 32'h100 + 32'(i)) begin
                errors++; $display("FAIL fetch_addr[%0d] got %h want %h", i, log_a[i+1], 32'h100 + 32'(i));
            end
        end
        @(posedge clk_in); #1;
        @(negedge clk_in);
        checks++; if (bus.if_done_o !== 1'b0) begin errors++; $display("FAIL fetch_pulse_width got %b want 0", bus.if_done_o); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL fetch_idle_busy got %b want 0", bus.busy_o); end
    endtask

    task automatic test_store;
        logic [7:0] exp_b [4];
        exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_txn(1'b0, 1'b1, 2'd2, 1'b0, 32'h200, 32'hDEAD_BEEF, -1, -1);
        checks++; if (done_cyc != 5) begin errors++; $display("FAIL store_done_cycle got %0d want 5", done_cyc); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_w[i+1] !== 1'b1 || log_d[i+1] !== exp_b[i] || log_a[i+1] !== 32'h200 + 32'(i)) begin
                errors++;
                $display("FAIL store_byte[%0d] got wr=%b d=%h a=%h want wr=1 d=%h a=%h",
                         i, log_w[i+1], log_d[i+1], log_a[i+1], exp_b[i], 32'h200 + 32'(i));
            end
        end
        checks++; if (log_w[5] !== 1'b0) begin errors++; $display("FAIL store_wr_done got %b want 0", log_w[5]); end
    endtask

    task automatic test_loads;
        run_txn(1'b0, 1'b0, 2'd0, 1'b1, 32'h201, 32'h0, -1, -1);
        checks++; if (done_cyc != 3) begin errors++; $display("FAIL lb_done_cycle got %0d want 3", done_cyc); end
        checks++; if (bus.ls_rdata_o !== 32'hFFFF_FFBE) begin errors++; $display("FAIL lb_signed got %h want FFFFFFBE", bus.ls_rdata_o); end
        run_txn(1'b0, 1'b0, 2'd0, 1'b0, 32'h201, 32'h0, -1, -1);
        checks++; if (bus.ls_rdata_o !== 32'h0000_00BE) begin errors++; $display("FAIL lbu got %h want 000000BE", bus.ls_rdata_o); end
        run_txn(1'b0, 1'b0, 2'd1, 1'b0, 32'h200, 32'h0, -1, -1);
        checks++; if (done_cyc != 4) begin errors++; $display("FAIL lhu_done_cycle got %0d want 4", done_cyc); end
        checks++; if (bus.ls_rdata_o !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu got %h want 0000BEEF", bus.ls_rdata_o); end
        run_txn(1'b0, 1'b0, 2'd1, 1'b1, 32'h202, 32'h0, -1, -1);
        checks++; if (bus.ls_rdata_o !== 32'hFFFF_DEAD) begin errors++; $display("FAIL lh_signed got %h want FFFFDEAD", bus.ls_rdata_o); end
        run_txn(1'b0, 1'b0, 2'd3, 1'b0, 32'h200, 32'h0, -1, -1);
        checks++; if (bus.ls_rdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_size3 got %h want DEADBEEF", bus.ls_rdata_o); end
    endtask

    task automatic test_arbitration;
        int ls_c;
        int if_c;
        ls_c = -1;
        if_c = -1;
        @(posedge clk_in); #1;
        bus.if_req_i   = 1'b1;
        bus.if_addr_i  = 32'h100;
        bus.ls_req_i   = 1'b1;
        bus.ls_we_i    = 1'b0;
        bus.ls_size_i  = 2'd2;
        bus.ls_sext_i  = 1'b0;
        bus.ls_addr_i  = 32'h200;
        for (int c = 0; c < 40 && if_c < 0; c++) begin
            if (c > 0) begin
                @(posedge clk_in); #1;
            end
            @(negedge clk_in);
            log_a[c] = bus.mem_a;
            if (bus.ls_done_o) begin ls_c = c; bus.ls_req_i = 1'b0; end
            if (bus.if_done_o) begin if_c = c; bus.if_req_i = 1'b0; end
        end
        checks++; if (ls_c != 6) begin errors++; $display("FAIL arb_ls_done got %0d want 6", ls_c); end
        checks++; if (if_c != 13) begin errors++; $display("FAIL arb_if_done got %0d want 13", if_c); end
        checks++; if (log_a[1] !== 32'h200) begin errors++; $display("FAIL arb_first_addr got %h want 200", log_a[1]); end
        checks++; if (log_a[8] !== 32'h100) begin errors++; $display("FAIL arb_fetch_addr got %h want 100", log_a[8]); end
        checks++; if (bus.ls_rdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL arb_rdata got %h want DEADBEEF", bus.ls_rdata_o); end
        checks++; if (bus.if_inst_o !== 32'h0010_0513) begin errors++; $display("FAIL arb_inst got %h want 00100513", bus.if_inst_o); end
    endtask

    task automatic test_stall;
        run_txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 3, 4);
        checks++; if (done_cyc != 10) begin errors++; $display("FAIL stall_rd_done got %0d want 10", done_cyc); end
        checks++; if (bus.if_inst_o !== 32'h0010_0513) begin errors++; $display("FAIL stall_rd_inst got %h want 00100513", bus.if_inst_o); end
        checks++; if (wr_any !== 1'b0) begin errors++; $display("FAIL stall_rd_no_write got %b want 0", wr_any); end
        run_txn(1'b0, 1'b1, 2'd2, 1'b0, 32'h300, 32'h1122_3344, 2, 2);
        checks++; if (done_cyc != 6) begin errors++; $display("FAIL stall_wr_done got %0d want 6", done_cyc); end
        checks++; if (log_w[2] !== 1'b0) begin errors++; $display("FAIL stall_wr_gated got %b want 0", log_w[2]); end
        run_txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, -1, -1);
        checks++; if (bus.ls_rdata_o !== 32'h1122_3344) begin errors++; $display("FAIL stall_wr_readback got %h want 11223344", bus.ls_rdata_o); end
    endtask

    task automatic test_misalign;
        run_txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h202, 32'h0, -1, -1);
`ifdef MEM_CTRL_ALIGN_CHK_EN
        checks++; if (done_cyc != 1) begin errors++; $display("FAIL mis_done got %0d want 1", done_cyc); end
        checks++; if (got_err !== 1'b1) begin errors++; $display("FAIL mis_err got %b want 1", got_err); end
        checks++; if (log_a[1] !== 32'h0) begin errors++; $display("FAIL mis_no_bus got %h want 0", log_a[1]); end
        checks++; if (bus.ls_rdata_o !== 32'h0) begin errors++; $display("FAIL mis_rdata got %h want 0", bus.ls_rdata_o); end
`else
        checks++; if (done_cyc != 6) begin errors++; $display("FAIL mis_done got %0d want 6", done_cyc); end
        checks++; if (got_err !== 1'b0) begin errors++; $display("FAIL mis_err got %b want 0", got_err); end
        checks++; if (log_a[4] !== 32'h205) begin errors++; $display("FAIL mis_last_addr got %h want 205", log_a[4]); end
        checks++; if (bus.ls_rdata_o !== 32'h6655_DEAD) begin errors++; $display("FAIL mis_rdata got %h want 6655DEAD", bus.ls_rdata_o); end
`endif
    endtask

    task automatic test_reset_abort;
        logic seen;
        seen = 1'b0;
        @(posedge clk_in); #1;
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h100;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        #1;
        checks++; if (bus.busy_o !== 1'b0 || bus.mem_a !== 32'h0) begin
            errors++; $display("FAIL abort_clear got busy=%b a=%h want busy=0 a=0", bus.busy_o, bus.mem_a);
        end
        bus.if_req_i = 1'b0;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_in);
            seen = seen | bus.if_done_o | bus.busy_o;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_done got %b want 0", seen); end
    endtask

    initial begin
        bus.if_req_i   = 1'b0;
        bus.if_addr_i  = 32'h0;
        bus.ls_req_i   = 1'b0;
        bus.ls_we_i    = 1'b0;
        bus.ls_size_i  = 2'd0;
        bus.ls_sext_i  = 1'b0;
        bus.ls_addr_i  = 32'h0;
        bus.ls_wdata_i = 32'h0;
        test_reset;
        preload(10'h100, 32'h0010_0513);
        preload(10'h204, 32'h0000_6655);
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        test_fetch;
        test_store;
        test_loads;
        test_arbitration;
        test_stall;
        test_misalign;
        test_reset_abort;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
